mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10: memory address width; the value comes from the shared memory header.
REQ-002 Parameter DATA_W, default 64: memory word width; the value comes from the shared memory header.
REQ-003 Parameter FREE_BASE, default 1: first allocatable address; address 0 is reserved as nil.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 mem_execute  input  1  request strobe from the initiator; held high until mem_ready.
REQ-007 mem_func  input  2  operation: 0 READ, 1 WRITE, 2 ALLOC, 3 reserved.
REQ-008 address1  input  ADDR_W  first read address, or the write address.
REQ-009 address2  input  ADDR_W  second read address.
REQ-010 write_data  input  DATA_W  word for WRITE and ALLOC.
REQ-011 mem_ready  output  1  one-cycle completion pulse.
REQ-012 read_data1  output  DATA_W  READ: mem[address1]; ALLOC: the allocated address, zero-extended.
REQ-013 read_data2  output  DATA_W  READ: mem[address2]; otherwise unchanged.
REQ-014 free_addr  output  ADDR_W  next address ALLOC will use.
REQ-015 mem_error  output  8  sticky error flags: bit0 ALLOC while full; bit1 reserved func; bit2 request aborted; bits 7:3 always 0.
REQ-016 busy  output  1  high from the accept edge until the module returns to IDLE.

Function
REQ-017 A request SHALL be accepted on the edge where mem_execute=1 and its registered copy exec_ff=0; address1, address2, mem_func and write_data SHALL be latched at that edge.
REQ-018 FSM states SHALL be: IDLE, RD_A, RD_B, RD_DONE, WR, ALLOC, WAIT_LOW.
- Transitions: IDLE->RD_A (READ), IDLE->WR (WRITE), IDLE->ALLOC (ALLOC), IDLE->WAIT_LOW (func 3).
REQ-019 READ: RD_A drives the RAM with address1; RD_B captures read_data1 and drives address2; RD_DONE captures read_data2.
- mem_ready SHALL be high in the cycle following the third edge after accept (latency 3).
REQ-020 WRITE: the RAM write to address1 SHALL occur in WR; mem_ready SHALL be high after the first edge after accept (latency 1).
REQ-021 ALLOC, not full: write_data SHALL be written to free_addr; read_data1 SHALL return the old free_addr; free_addr SHALL then increment; latency 1.
REQ-022 ALLOC at free_addr = 2^ADDR_W-1: the write SHALL occur, the internal full flag SHALL set, and free_addr SHALL hold (no wrap).
REQ-023 ALLOC while full: no write; mem_error[0] SHALL set; mem_ready SHALL still pulse with latency 1; read_data1 SHALL be 0.
REQ-024 func 3: no RAM access; mem_error[1] SHALL set; mem_ready SHALL pulse with latency 1.
REQ-025 After mem_ready the FSM SHALL sit in WAIT_LOW until mem_execute=0, then return to IDLE.
- A still-high mem_execute SHALL never be re-accepted.
REQ-026 If mem_execute falls before mem_ready is issued:
- the FSM SHALL return to IDLE at the next edge;
- mem_error[2] SHALL set;
- mem_ready SHALL NOT pulse;
- a not-yet-performed write SHALL be suppressed.
REQ-027 mem_ready SHALL be exactly one cycle wide per accepted request.
REQ-028 read_data1 and read_data2 SHALL hold their last values until overwritten.

Reset
REQ-029 On rst low, the following SHALL take these values immediately:
- state=IDLE; mem_ready=0; busy=0;
- read_data1=read_data2=0; mem_error=0;
- free_addr=FREE_BASE; full=0; exec_ff=0.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 A reset asserted mid-operation SHALL abandon the operation with no further write.

Structure
REQ-032 The shared header memory_unit.vh SHALL hold the address/data widths and the mem_func codes.
REQ-033 Storage SHALL be a single sub-module, mem_ram_sp: single-port synchronous RAM, 2^ADDR_W x DATA_W, one-cycle read latency.

Verification
REQ-034 WRITE addr 5 data 0xDEAD, then READ a1=5 a2=0 -> mem_ready after 1 and 3 cycles; read_data1=0xDEAD.
REQ-035 ALLOC 0x11 then ALLOC 0x22 after reset -> read_data1=1 then 2; free_addr=3; READ 1,2 returns 0x11, 0x22.
REQ-036 Preload free_addr to 1023 via ALLOCs; ALLOC, ALLOC -> first writes 1023; second sets mem_error[0], read_data1=0, free_addr=1023.
REQ-037 READ request, mem_execute dropped after 1 cycle -> no mem_ready; mem_error=0x04; next request serviced normally.
REQ-038 mem_execute held high 10 cycles after mem_ready -> exactly one mem_ready; func=3 request -> mem_error[1]=1 with one mem_ready.
REQ-039 rst pulsed during RD_B -> outputs reset values; free_addr=1; a subsequent READ completes with latency 3.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared memory definitions for the responder slice: address/data widths,
// operation codes, error flag masks and the controller state encoding.
package mem_responder_pkg;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned MEM_DATA_W = 64;
    localparam int unsigned MEM_FUNC_W = 2;
    localparam int unsigned MEM_ERR_W  = 8;

    typedef enum logic [MEM_FUNC_W-1:0] {
        FUNC_READ  = 2'd0,
        FUNC_WRITE = 2'd1,
        FUNC_ALLOC = 2'd2,
        FUNC_RSVD  = 2'd3
    } mem_func_e;

    // Sticky error flag masks; bits 7:3 are never set.
    localparam logic [MEM_ERR_W-1:0] ERR_FULL  = 8'h01;
    localparam logic [MEM_ERR_W-1:0] ERR_FUNC  = 8'h02;
    localparam logic [MEM_ERR_W-1:0] ERR_ABORT = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_A     = 3'd1,
        ST_RD_B     = 3'd2,
        ST_RD_DONE  = 3'd3,
        ST_WR       = 3'd4,
        ST_ALLOC    = 3'd5,
        ST_WAIT_LOW = 3'd6
    } state_e;

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous RAM, 2^ADDR_W x DATA_W, one-cycle read latency.
// Contents are not reset.
// Ports:
//   clk     - clock
//   we_i    - write enable for the current address
//   addr_i  - shared read/write address
//   wdata_i - write word
//   rdata_o - registered read word (old contents on a write cycle)
module mem_ram_sp
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-before-write storage array.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory request responder: services READ (two addresses), WRITE and ALLOC
// (bump allocator) requests from a level-held mem_execute handshake against
// a single-port RAM, reporting completion with a one-cycle mem_ready pulse.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   mem_execute       - request strobe, held high until mem_ready
//   mem_func          - 0 READ, 1 WRITE, 2 ALLOC, 3 reserved
//   address1/2        - read addresses (address1 is also the write address)
//   write_data        - word for WRITE and ALLOC
//   mem_ready         - one-cycle completion pulse
//   read_data1/2      - READ results; read_data1 returns the ALLOC address
//   free_addr         - next address ALLOC will use
//   mem_error         - sticky flags: [0] alloc full, [1] bad func, [2] abort
//   busy              - request in flight (not IDLE)
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W,
    parameter int unsigned FREE_BASE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_execute,
    input  logic [MEM_FUNC_W-1:0] mem_func,
    input  logic [ADDR_W-1:0]     address1,
    input  logic [ADDR_W-1:0]     address2,
    input  logic [DATA_W-1:0]     write_data,
    output logic                  mem_ready,
    output logic [DATA_W-1:0]     read_data1,
    output logic [DATA_W-1:0]     read_data2,
    output logic [ADDR_W-1:0]     free_addr,
    output logic [MEM_ERR_W-1:0]  mem_error,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_e                 state_q, state_d;
    logic                   exec_ff_q;
    logic                   pend_q, pend_d;
    logic [ADDR_W-1:0]      a1_q, a1_d;
    logic [ADDR_W-1:0]      a2_q, a2_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rd1_q, rd1_d;
    logic [DATA_W-1:0]      rd2_q, rd2_d;
    logic                   ready_q, ready_d;
    logic                   busy_q;
    logic [ADDR_W-1:0]      free_q, free_d;
    logic                   full_q, full_d;
    logic [MEM_ERR_W-1:0]   err_q, err_d;
    logic                   ram_we_c;
    logic [ADDR_W-1:0]      ram_addr_c;
    logic [DATA_W-1:0]      ram_rdata_c;

    mem_ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_c),
        .addr_i  (ram_addr_c),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, RAM control and datapath updates.
    always_comb begin
        state_d    = state_q;
        pend_d     = 1'b0;
        a1_d       = a1_q;
        a2_d       = a2_q;
        wdata_d    = wdata_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        ready_d    = 1'b0;
        free_d     = free_q;
        full_d     = full_q;
        err_d      = err_q;
        ram_we_c   = 1'b0;
        ram_addr_c = a1_q;

        unique case (state_q)
            ST_IDLE: begin
                // Accept only on a fresh rising request.
                if (mem_execute && !exec_ff_q) begin
                    a1_d    = address1;
                    a2_d    = address2;
                    wdata_d = write_data;
                    case (mem_func_e'(mem_func))
                        FUNC_READ:  state_d = ST_RD_A;
                        FUNC_WRITE: state_d = ST_WR;
                        FUNC_ALLOC: state_d = ST_ALLOC;
                        default: begin
                            // Reserved func completes one cycle later from WAIT_LOW.
                            state_d = ST_WAIT_LOW;
                            pend_d  = 1'b1;
                            err_d   = err_q | ERR_FUNC;
                        end
                    endcase
                end
            end

            ST_RD_A: begin
                ram_addr_c = a1_q;
                if (!mem_execute) begin
                    state_d = ST_IDLE;
                    err_d   = err_q | ERR_ABORT;
                end else begin
                    state_d = ST_RD_B;
                end
            end

            ST_RD_B: begin
                ram_addr_c = a2_q;
                if (!mem_execute) begin
                    state_d = ST_IDLE;
                    err_d   = err_q | ERR_ABORT;
                end else begin
                    rd1_d   = ram_rdata_c;
                    state_d = ST_RD_DONE;
                end
            end

            ST_RD_DONE: begin
                if (!mem_execute) begin
                    state_d = ST_IDLE;
                    err_d   = err_q | ERR_ABORT;
                end else begin
                    rd2_d   = ram_rdata_c;
                    ready_d = 1'b1;
                    state_d = ST_WAIT_LOW;
                end
            end

            ST_WR: begin
                ram_addr_c = a1_q;
                if (!mem_execute) begin
                    state_d = ST_IDLE;
                    err_d   = err_q | ERR_ABORT;
                end else begin
                    ram_we_c = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = ST_WAIT_LOW;
                end
            end

            ST_ALLOC: begin
                ram_addr_c = free_q;
                if (!mem_execute) begin
                    state_d = ST_IDLE;
                    err_d   = err_q | ERR_ABORT;
                end else begin
                    ready_d = 1'b1;
                    state_d = ST_WAIT_LOW;
                    if (full_q) begin
                        rd1_d = '0;
                        err_d = err_q | ERR_FULL;
                    end else begin
                        ram_we_c = 1'b1;
                        rd1_d    = DATA_W'(free_q);
                        // The last address is handed out once, then the pool is full.
                        if (free_q == ADDR_MAX) begin
                            full_d = 1'b1;
                        end else begin
                            free_d = free_q + ADDR_W'(1);
                        end
                    end
                end
            end

            ST_WAIT_LOW: begin
                if (pend_q) begin
                    if (!mem_execute) begin
                        state_d = ST_IDLE;
                        err_d   = err_q | ERR_ABORT;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else if (!mem_execute) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exec_ff_q <= 1'b0;
            pend_q    <= 1'b0;
            a1_q      <= '0;
            a2_q      <= '0;
            wdata_q   <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            free_q    <= ADDR_W'(FREE_BASE);
            full_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            exec_ff_q <= mem_execute;
            pend_q    <= pend_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            wdata_q   <= wdata_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            ready_q   <= ready_d;
            busy_q    <= (state_d != ST_IDLE);
            free_q    <= free_d;
            full_q    <= full_d;
            err_q     <= err_d;
        end
    end

    assign mem_ready  = ready_q;
    assign read_data1 = rd1_q;
    assign read_data2 = rd2_q;
    assign free_addr  = free_q;
    assign mem_error  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a behavioural memory/allocator model
// pushes expected responses into a scoreboard queue as each request is driven;
// each scenario task pops and compares them when mem_ready arrives.
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_execute = 1'b0;
    logic [1:0]    mem_func = 2'd0;
    logic [AW-1:0] address1 = '0;
    logic [AW-1:0] address2 = '0;
    logic [DW-1:0] write_data = '0;
    logic          mem_ready;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic [AW-1:0] free_addr;
    logic [7:0]    mem_error;
    logic          busy;

    mem_responder #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .FREE_BASE (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_execute (mem_execute),
        .mem_func    (mem_func),
        .address1    (address1),
        .address2    (address2),
        .write_data  (write_data),
        .mem_ready   (mem_ready),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .free_addr   (free_addr),
        .mem_error   (mem_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    f;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] wd;
        int            hold;
    } req_t;

    typedef struct {
        int            lat;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        bit            k1;
        bit            k2;
        logic [AW-1:0] free;
        logic [7:0]    err;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl_mem [int];
    logic [DW-1:0] m_rd1, m_rd2;
    bit            m_k1, m_k2;
    logic [AW-1:0] m_free;
    bit            m_full;
    logic [7:0]    m_err;

    int n_chk = 0;
    int n_err = 0;
    int ready_cnt = 0;

    always @(negedge clk) begin
        if (mem_ready === 1'b1) ready_cnt++;
    end

    // Model state after reset; RAM contents are deliberately kept.
    task automatic model_reset();
        m_rd1 = '0; m_rd2 = '0; m_k1 = 1'b1; m_k2 = 1'b1;
        m_free = AW'(1); m_full = 1'b0; m_err = 8'h00;
    endtask

    // Predict one request and push the expected response.
    task automatic model_req(input req_t rq);
        exp_t e;
        e.lat = 1;
        case (rq.f)
            2'd0: begin
                m_k1 = mdl_mem.exists(int'(rq.a1));
                m_rd1 = m_k1 ? mdl_mem[int'(rq.a1)] : '0;
                m_k2 = mdl_mem.exists(int'(rq.a2));
                m_rd2 = m_k2 ? mdl_mem[int'(rq.a2)] : '0;
                e.lat = 3;
            end
            2'd1: mdl_mem[int'(rq.a1)] = rq.wd;
            2'd2: begin
                m_k1 = 1'b1;
                if (m_full) begin
                    m_rd1 = '0;
                    m_err = m_err | 8'h01;
                end else begin
                    mdl_mem[int'(m_free)] = rq.wd;
                    m_rd1 = DW'(m_free);
                    if (m_free == 10'h3FF) m_full = 1'b1;
                    else m_free = m_free + 10'd1;
                end
            end
            default: m_err = m_err | 8'h02;
        endcase
        e.r1 = m_rd1; e.r2 = m_rd2; e.k1 = m_k1; e.k2 = m_k2;
        e.free = m_free; e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        mem_execute = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Drive one request, wait (bounded) for mem_ready, then release.
    task automatic issue(input req_t rq, output int lat, output logic [DW-1:0] r1,
                         output logic [DW-1:0] r2, output bit got);
        @(negedge clk);
        mem_func = rq.f; address1 = rq.a1; address2 = rq.a2;
        write_data = rq.wd; mem_execute = 1'b1;
        got = 1'b0; lat = -1; r1 = '0; r2 = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                got = 1'b1; lat = i; r1 = read_data1; r2 = read_data2;
            end
        end
        repeat (rq.hold) @(negedge clk);
        mem_execute = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #2;
        n_chk++;
        if ({mem_ready, busy} !== 2'b00) begin
            n_err++; $display("FAIL reset_ctrl ready/busy got %b%b exp 00", mem_ready, busy);
        end
        n_chk++;
        if ({read_data1, read_data2} !== 128'h0) begin
            n_err++; $display("FAIL reset_data got %h/%h exp 0/0", read_data1, read_data2);
        end
        n_chk++;
        if ({mem_error, free_addr} !== {8'h00, 10'd1}) begin
            n_err++; $display("FAIL reset_state err/free got %h/%0d exp 00/1", mem_error, free_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_write_read();
        req_t rq[$]; exp_t e; int lat; logic [DW-1:0] r1, r2; bit got;
        rq.push_back('{2'd1, 10'd5, 10'd0, 64'hDEAD, 0});
        rq.push_back('{2'd0, 10'd5, 10'd0, 64'h0, 0});
        rq.push_back('{2'd1, 10'd0, 10'd0, 64'h1234_5678_9ABC_DEF0, 0});
        rq.push_back('{2'd0, 10'd0, 10'd5, 64'h0, 0});
        foreach (rq[j]) begin
            model_req(rq[j]);
            issue(rq[j], lat, r1, r2, got);
            e = sb.pop_front();
            n_chk++;
            if (!got || lat != e.lat) begin
                n_err++; $display("FAIL wr_rd[%0d] latency got %0d (ready %0b) exp %0d", j, lat, got, e.lat);
            end
            if (e.k1) begin
                n_chk++;
                if (r1 !== e.r1) begin n_err++; $display("FAIL wr_rd[%0d] read_data1 got %h exp %h", j, r1, e.r1); end
            end
            if (e.k2) begin
                n_chk++;
                if (r2 !== e.r2) begin n_err++; $display("FAIL wr_rd[%0d] read_data2 got %h exp %h", j, r2, e.r2); end
            end
            n_chk++;
            if ({free_addr, mem_error, busy} !== {e.free, e.err, 1'b0}) begin
                n_err++; $display("FAIL wr_rd[%0d] free/err/busy got %0d/%h/%b exp %0d/%h/0", j, free_addr, mem_error, busy, e.free, e.err);
            end
        end
    endtask

    task automatic test_alloc();
        req_t rq[$]; exp_t e; int lat; logic [DW-1:0] r1, r2; bit got;
        apply_reset();
        rq.push_back('{2'd2, 10'd0, 10'd0, 64'h11, 0});
        rq.push_back('{2'd2, 10'd0, 10'd0, 64'h22, 0});
        rq.push_back('{2'd0, 10'd1, 10'd2, 64'h0, 0});
        foreach (rq[j]) begin
            model_req(rq[j]);
            issue(rq[j], lat, r1, r2, got);
            e = sb.pop_front();
            n_chk++;
            if (!got || lat != e.lat) begin
                n_err++; $display("FAIL alloc[%0d] latency got %0d (ready %0b) exp %0d", j, lat, got, e.lat);
            end
            if (e.k1) begin
                n_chk++;
                if (r1 !== e.r1) begin n_err++; $display("FAIL alloc[%0d] read_data1 got %h exp %h", j, r1, e.r1); end
            end
            if (e.k2) begin
                n_chk++;
                if (r2 !== e.r2) begin n_err++; $display("FAIL alloc[%0d] read_data2 got %h exp %h", j, r2, e.r2); end
            end
            n_chk++;
            if ({free_addr, mem_error, busy} !== {e.free, e.err, 1'b0}) begin
                n_err++; $display("FAIL alloc[%0d] free/err/busy got %0d/%h/%b exp %0d/%h/0", j, free_addr, mem_error, busy, e.free, e.err);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        req_t rq; exp_t e; int lat; logic [DW-1:0] r1, r2; bit got;
        @(negedge clk);
        mem_func = 2'd0; address1 = 10'd1; address2 = 10'd2; mem_execute = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        if ({mem_ready, busy, mem_error} !== {1'b0, 1'b0, 8'h00}) begin
            n_err++; $display("FAIL mid_rst_ctrl ready/busy/err got %b/%b/%h exp 0/0/00", mem_ready, busy, mem_error);
        end
        n_chk++;
        if ({read_data1, read_data2} !== 128'h0) begin
            n_err++; $display("FAIL mid_rst_data got %h/%h exp 0/0", read_data1, read_data2);
        end
        n_chk++;
        if (free_addr !== 10'd1) begin
            n_err++; $display("FAIL mid_rst_free got %0d exp 1", free_addr);
        end
        mem_execute = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        rq = '{2'd0, 10'd1, 10'd2, 64'h0, 0};
        model_req(rq);
        issue(rq, lat, r1, r2, got);
        e = sb.pop_front();
        n_chk++;
        if (!got || lat != e.lat) begin
            n_err++; $display("FAIL mid_rst_read latency got %0d (ready %0b) exp %0d", lat, got, e.lat);
        end
        n_chk++;
        if ({r1, r2} !== {e.r1, e.r2}) begin
            n_err++; $display("FAIL mid_rst_read data got %h/%h exp %h/%h", r1, r2, e.r1, e.r2);
        end
    endtask

    task automatic test_abort();
        req_t rq; exp_t e; int lat; logic [DW-1:0] r1, r2; bit got; int c0;
        c0 = ready_cnt;
        @(negedge clk);
        mem_func = 2'd0; address1 = 10'd5; address2 = 10'd0; mem_execute = 1'b1;
        @(negedge clk);
        mem_execute = 1'b0;
        repeat (4) @(negedge clk);
        m_err = m_err | 8'h04;
        n_chk++;
        if (ready_cnt != c0) begin
            n_err++; $display("FAIL abort_no_ready pulses got %0d exp 0", ready_cnt - c0);
        end
        n_chk++;
        if ({mem_error, busy} !== {8'h04, 1'b0}) begin
            n_err++; $display("FAIL abort_state err/busy got %h/%b exp 04/0", mem_error, busy);
        end
        rq = '{2'd0, 10'd5, 10'd1, 64'h0, 0};
        model_req(rq);
        issue(rq, lat, r1, r2, got);
        e = sb.pop_front();
        n_chk++;
        if (!got || lat != e.lat) begin
            n_err++; $display("FAIL abort_next latency got %0d (ready %0b) exp %0d", lat, got, e.lat);
        end
        n_chk++;
        if ({r1, r2, mem_error} !== {e.r1, e.r2, e.err}) begin
            n_err++; $display("FAIL abort_next data/err got %h/%h/%h exp %h/%h/%h", r1, r2, mem_error, e.r1, e.r2, e.err);
        end
    endtask

    task automatic test_hold_and_rsvd();
        req_t rq[$]; exp_t e; int lat; logic [DW-1:0] r1, r2; bit got; int c0;
        apply_reset();
        c0 = ready_cnt;
        rq.push_back('{2'd1, 10'd9, 10'd0, 64'h9999, 10});
        rq.push_back('{2'd3, 10'd9, 10'd9, 64'h7777, 0});
        rq.push_back('{2'd0, 10'd9, 10'd9, 64'h0, 0});
        foreach (rq[j]) begin
            model_req(rq[j]);
            issue(rq[j], lat, r1, r2, got);
            e = sb.pop_front();
            n_chk++;
            if (!got || lat != e.lat) begin
                n_err++; $display("FAIL hold[%0d] latency got %0d (ready %0b) exp %0d", j, lat, got, e.lat);
            end
            if (e.k1) begin
                n_chk++;
                if (r1 !== e.r1) begin n_err++; $display("FAIL hold[%0d] read_data1 got %h exp %h", j, r1, e.r1); end
            end
            if (e.k2) begin
                n_chk++;
                if (r2 !== e.r2) begin n_err++; $display("FAIL hold[%0d] read_data2 got %h exp %h", j, r2, e.r2); end
            end
            n_chk++;
            if ({free_addr, mem_error, busy} !== {e.free, e.err, 1'b0}) begin
                n_err++; $display("FAIL hold[%0d] free/err/busy got %0d/%h/%b exp %0d/%h/0", j, free_addr, mem_error, busy, e.free, e.err);
            end
        end
        n_chk++;
        if (ready_cnt - c0 != 3) begin
            n_err++; $display("FAIL hold_pulses mem_ready pulses got %0d exp 3", ready_cnt - c0);
        end
    endtask

    task automatic test_alloc_full();
        req_t rq[$]; req_t one; exp_t e; int lat; logic [DW-1:0] r1, r2; bit got; int bad;
        apply_reset();
        bad = 0;
        for (int a = 1; a <= 1022; a++) begin
            one = '{2'd2, 10'd0, 10'd0, 64'hC0DE_0000 | DW'(a), 0};
            model_req(one);
            issue(one, lat, r1, r2, got);
            e = sb.pop_front();
            if (!got || r1 !== e.r1) bad++;
        end
        n_chk++;
        if (bad != 0 || free_addr !== 10'd1023) begin
            n_err++; $display("FAIL fill bad allocs %0d free got %0d exp 0 bad, free 1023", bad, free_addr);
        end
        rq.push_back('{2'd2, 10'd0, 10'd0, 64'hAAAA, 0});
        rq.push_back('{2'd2, 10'd0, 10'd0, 64'hBBBB, 0});
        rq.push_back('{2'd0, 10'd1023, 10'd1022, 64'h0, 0});
        foreach (rq[j]) begin
            model_req(rq[j]);
            issue(rq[j], lat, r1, r2, got);
            e = sb.pop_front();
            n_chk++;
            if (!got || lat != e.lat) begin
                n_err++; $display("FAIL full[%0d] latency got %0d (ready %0b) exp %0d", j, lat, got, e.lat);
            end
            if (e.k1) begin
                n_chk++;
                if (r1 !== e.r1) begin n_err++; $display("FAIL full[%0d] read_data1 got %h exp %h", j, r1, e.r1); end
            end
            if (e.k2) begin
                n_chk++;
                if (r2 !== e.r2) begin n_err++; $display("FAIL full[%0d] read_data2 got %h exp %h", j, r2, e.r2); end
            end
            n_chk++;
            if ({free_addr, mem_error, busy} !== {e.free, e.err, 1'b0}) begin
                n_err++; $display("FAIL full[%0d] free/err/busy got %0d/%h/%b exp %0d/%h/0", j, free_addr, mem_error, busy, e.free, e.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alloc();
        test_reset_mid_read();
        test_abort();
        test_hold_and_rsvd();
        test_alloc_full();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
